// File: rtl/id_ex_hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_ex_hazard_ctrl_if: ID-stage operand info in, pipeline controls  |
// | and stall statistics out.                          Revision: 1.0   |
// +--------------------------------------------------------------------+
interface id_ex_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              Valid_ID;
  logic [REG_AW-1:0] Rs1_ID;
  logic [REG_AW-1:0] Rs2_ID;
  logic              Rs1_used;
  logic              Rs2_used;
  logic [REG_AW-1:0] Rd_ID;
  logic              RegWrite_ID;
  logic              Flush;
  logic              Stall;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              Bubble;
  logic              State;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  MaxStall;

  modport master (
    output Valid_ID, Rs1_ID, Rs2_ID, Rs1_used, Rs2_used, Rd_ID, RegWrite_ID, Flush,
    input  Stall, PCWrite, IFIDWrite, Bubble, State, StallCount, MaxStall
  );

  modport slave (
    input  Valid_ID, Rs1_ID, Rs2_ID, Rs1_used, Rs2_used, Rd_ID, RegWrite_ID, Flush,
    output Stall, PCWrite, IFIDWrite, Bubble, State, StallCount, MaxStall
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_ex_hazard_ctrl: scoreboard-based RAW interlock for the ID/EX    |
// | register of a forwarding-less 5-stage core.        Revision: 1.0   |
// +--------------------------------------------------------------------+
module id_ex_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  wire logic           Clk,
  input  wire logic           Reset,
  id_ex_hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q;
  logic [DEPTH-1:0]  sb_v_q;
  logic [REG_AW-1:0] sb_rd_q [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  max_stall_q;
  logic [CNT_W-1:0]  run_q;

  logic hit1;
  logic hit2;
  logic hazard;
  logic bubble;
  logic push;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_v_q[i] && (sb_rd_q[i] == bus.Rs1_ID)) hit1 = 1'b1;
      if (sb_v_q[i] && (sb_rd_q[i] == bus.Rs2_ID)) hit2 = 1'b1;
    end
  end

  // Reset masks the hazard so the stall is abandoned in the reset cycle itself.
  assign hazard = !Reset && bus.Valid_ID && !bus.Flush &&
                  ((bus.Rs1_used && (bus.Rs1_ID != '0) && hit1) ||
                   (bus.Rs2_used && (bus.Rs2_ID != '0) && hit2));
  assign bubble = hazard || bus.Flush || !bus.Valid_ID;
  assign push   = bus.Valid_ID && bus.RegWrite_ID && (bus.Rd_ID != '0) && !bubble;

  assign bus.Stall      = hazard;
  assign bus.PCWrite    = !hazard || bus.Flush;
  assign bus.IFIDWrite  = !hazard || bus.Flush;
  assign bus.Bubble     = bubble;
  assign bus.State      = state_q;
  assign bus.StallCount = stall_cnt_q;
  assign bus.MaxStall   = max_stall_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RUN;
      sb_v_q      <= '0;
      stall_cnt_q <= '0;
      max_stall_q <= '0;
      run_q       <= '0;
      for (int i = 0; i < DEPTH; i++) sb_rd_q[i] <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sb_v_q[i]  <= sb_v_q[i-1];
        sb_rd_q[i] <= sb_rd_q[i-1];
      end
      sb_v_q[0]  <= push;
      sb_rd_q[0] <= push ? bus.Rd_ID : '0;

      if (hazard && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_ONE;

      case (state_q)
        RUN: begin
          if (hazard) begin
            state_q <= STALL;
            run_q   <= CNT_ONE;
          end
        end
        STALL: begin
          if (hazard) begin
            if (run_q != CNT_MAX) run_q <= run_q + CNT_ONE;
          end else begin
            state_q <= RUN;
            run_q   <= '0;
            if (run_q > max_stall_q) max_stall_q <= run_q;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_id_ex_hazard_ctrl: directed scenarios for the ID/EX interlock.  |
// |                                                    Revision: 1.0   |
// +--------------------------------------------------------------------+
module tb_id_ex_hazard_ctrl;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  id_ex_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifa ();
  id_ex_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifb ();

  id_ex_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .CNT_W(16)) dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa.slave));
  id_ex_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .CNT_W(4))  dut_b (.Clk(Clk), .Reset(Reset), .bus(ifb.slave));

  // The narrow-counter instance sees exactly the same instruction stream.
  assign ifb.Valid_ID    = ifa.Valid_ID;
  assign ifb.Rs1_ID      = ifa.Rs1_ID;
  assign ifb.Rs2_ID      = ifa.Rs2_ID;
  assign ifb.Rs1_used    = ifa.Rs1_used;
  assign ifb.Rs2_used    = ifa.Rs2_used;
  assign ifb.Rd_ID       = ifa.Rd_ID;
  assign ifb.RegWrite_ID = ifa.RegWrite_ID;
  assign ifb.Flush       = ifa.Flush;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic fl);
    ifa.Valid_ID    = v;
    ifa.Rs1_ID      = rs1;
    ifa.Rs1_used    = u1;
    ifa.Rs2_ID      = rs2;
    ifa.Rs2_used    = u2;
    ifa.Rd_ID       = rd;
    ifa.RegWrite_ID = rw;
    ifa.Flush       = fl;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(1, 5'd3, 1, 5'd4, 1, 5'd6, 1, 0);
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", ifa.Stall); end
    n_checks++; if (ifa.PCWrite !== 1'b1) begin n_fail++; $display("FAIL reset_pcwrite got %b exp 1", ifa.PCWrite); end
    n_checks++; if (ifa.Bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %b exp 0", ifa.Bubble); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.State !== 1'b0) begin n_fail++; $display("FAIL reset_state got %b exp 0", ifa.State); end
    n_checks++; if (ifa.StallCount !== 16'd0) begin n_fail++; $display("FAIL reset_stallcount got %0d exp 0", ifa.StallCount); end
    n_checks++; if (ifa.MaxStall !== 16'd0) begin n_fail++; $display("FAIL reset_maxstall got %0d exp 0", ifa.MaxStall); end
    n_checks++; if (ifa.Bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble_idle got %b exp 1", ifa.Bubble); end
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_adjacent_raw();
    logic exp;
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd5, 1, 0);
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b0) begin n_fail++; $display("FAIL adj_producer_stall got %b exp 0", ifa.Stall); end
    tick();
    drive(1, 5'd5, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp = (i < 3);
      @(negedge Clk);
      n_checks++; if (ifa.Stall !== exp) begin n_fail++; $display("FAIL adj_stall cyc%0d got %b exp %b", i, ifa.Stall, exp); end
      n_checks++; if (ifa.Bubble !== exp) begin n_fail++; $display("FAIL adj_bubble cyc%0d got %b exp %b", i, ifa.Bubble, exp); end
      n_checks++; if (ifa.PCWrite !== !exp) begin n_fail++; $display("FAIL adj_pcwrite cyc%0d got %b exp %b", i, ifa.PCWrite, !exp); end
      n_checks++; if (ifa.IFIDWrite !== !exp) begin n_fail++; $display("FAIL adj_ifidwrite cyc%0d got %b exp %b", i, ifa.IFIDWrite, !exp); end
      n_checks++; if (ifa.State !== (i > 0)) begin n_fail++; $display("FAIL adj_state cyc%0d got %b exp %b", i, ifa.State, (i > 0)); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.State !== 1'b0) begin n_fail++; $display("FAIL adj_state_end got %b exp 0", ifa.State); end
    n_checks++; if (ifa.StallCount !== 16'd3) begin n_fail++; $display("FAIL adj_stallcount got %0d exp 3", ifa.StallCount); end
    n_checks++; if (ifa.MaxStall !== 16'd3) begin n_fail++; $display("FAIL adj_maxstall got %0d exp 3", ifa.MaxStall); end
  endtask

  task automatic test_gap_raw();
    logic exp;
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd7, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 5'd3, 1, 0);
    tick();
    drive(1, 0, 0, 5'd7, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      exp = (i < 2);
      @(negedge Clk);
      n_checks++; if (ifa.Stall !== exp) begin n_fail++; $display("FAIL gap_stall cyc%0d got %b exp %b", i, ifa.Stall, exp); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.StallCount !== 16'd2) begin n_fail++; $display("FAIL gap_stallcount got %0d exp 2", ifa.StallCount); end
    n_checks++; if (ifa.MaxStall !== 16'd2) begin n_fail++; $display("FAIL gap_maxstall got %0d exp 2", ifa.MaxStall); end
  endtask

  task automatic test_x0_and_unused();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd0, 1, 0);
    tick();
    drive(1, 5'd0, 1, 5'd0, 1, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %b exp 0", ifa.Stall); end
    tick();
    drive(1, 0, 0, 0, 0, 5'd9, 1, 0);
    tick();
    drive(1, 5'd9, 0, 5'd9, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b0) begin n_fail++; $display("FAIL unused_stall got %b exp 0", ifa.Stall); end
    tick();
    drive(1, 5'd9, 1, 0, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b1) begin n_fail++; $display("FAIL used_stall got %b exp 1", ifa.Stall); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd5, 1, 0);
    tick();
    drive(1, 5'd5, 1, 0, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall got %b exp 1", ifa.Stall); end
    tick();
    drive(1, 5'd5, 1, 0, 0, 5'd6, 1, 1);
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", ifa.Stall); end
    n_checks++; if (ifa.Bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble got %b exp 1", ifa.Bubble); end
    n_checks++; if (ifa.PCWrite !== 1'b1) begin n_fail++; $display("FAIL flush_pcwrite got %b exp 1", ifa.PCWrite); end
    n_checks++; if (ifa.IFIDWrite !== 1'b1) begin n_fail++; $display("FAIL flush_ifidwrite got %b exp 1", ifa.IFIDWrite); end
    tick();
    drive(1, 5'd6, 1, 0, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b0) begin n_fail++; $display("FAIL flush_killed_rd got %b exp 0", ifa.Stall); end
    n_checks++; if (ifa.State !== 1'b0) begin n_fail++; $display("FAIL flush_state got %b exp 0", ifa.State); end
    n_checks++; if (ifa.MaxStall !== 16'd1) begin n_fail++; $display("FAIL flush_maxstall got %0d exp 1", ifa.MaxStall); end
    n_checks++; if (ifa.StallCount !== 16'd1) begin n_fail++; $display("FAIL flush_stallcount got %0d exp 1", ifa.StallCount); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd5, 1, 0);
    tick();
    drive(1, 5'd5, 1, 0, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b1) begin n_fail++; $display("FAIL rststall_pre got %b exp 1", ifa.Stall); end
    tick();
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b0) begin n_fail++; $display("FAIL rststall_during got %b exp 0", ifa.Stall); end
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    n_checks++; if (ifa.Stall !== 1'b0) begin n_fail++; $display("FAIL rststall_after got %b exp 0", ifa.Stall); end
    n_checks++; if (ifa.State !== 1'b0) begin n_fail++; $display("FAIL rststall_state got %b exp 0", ifa.State); end
    n_checks++; if (ifa.StallCount !== 16'd0) begin n_fail++; $display("FAIL rststall_stallcount got %0d exp 0", ifa.StallCount); end
    n_checks++; if (ifa.MaxStall !== 16'd0) begin n_fail++; $display("FAIL rststall_maxstall got %0d exp 0", ifa.MaxStall); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd5, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 5'd6, 1, 0);
    tick();
    drive(1, 5'd5, 1, 5'd6, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifa.StallCount !== 16'd3) begin n_fail++; $display("FAIL b2b_stallcount got %0d exp 3", ifa.StallCount); end
    n_checks++; if (ifa.MaxStall !== 16'd3) begin n_fail++; $display("FAIL b2b_maxstall got %0d exp 3", ifa.MaxStall); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      drive(1, 0, 0, 0, 0, 5'd5, 1, 0);
      tick();
      drive(1, 5'd5, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    n_checks++; if (ifb.StallCount !== 4'd15) begin n_fail++; $display("FAIL sat_stallcount got %0d exp 15", ifb.StallCount); end
    n_checks++; if (ifb.MaxStall !== 4'd3) begin n_fail++; $display("FAIL sat_maxstall got %0d exp 3", ifb.MaxStall); end
    n_checks++; if (ifa.StallCount !== 16'd18) begin n_fail++; $display("FAIL wide_stallcount got %0d exp 18", ifa.StallCount); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_adjacent_raw();
    test_gap_raw();
    test_x0_and_unused();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
